// File: rtl/vigenere_pkg.sv
// Shared constants and state encoding for the Vigenere cipher datapath.
package vigenere_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam int         ALPHA_N = 26;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/vigenere_alpha_shift.sv
// Combinational mod-26 letter shift; encrypt adds the key, decrypt subtracts it.
module vigenere_alpha_shift
  import vigenere_pkg::*;
(
  input  logic [4:0] p,
  input  logic [4:0] k,
  input  logic       mode,
  output logic [4:0] result
);

  logic [5:0] sum;

  // Operands are both < 26, so a single conditional subtract reduces to 0..25.
  always_comb begin
    sum = '0;
    if (mode == MODE_DEC)
      sum = {1'b0, p} + 6'(ALPHA_N) - {1'b0, k};
    else
      sum = {1'b0, p} + {1'b0, k};
    result = (sum >= 6'(ALPHA_N)) ? 5'(sum - 6'(ALPHA_N)) : sum[4:0];
  end

endmodule

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere cipher: serial key load FSM, key store, wrapping key pointer
// and a single registered output stage with valid/ready handshakes.
module vigenere_stream_cipher
  import vigenere_pkg::*;
#(
  parameter int MAX_KEY_LEN   = 10,
  parameter int PTR_W         = $clog2(MAX_KEY_LEN),
  parameter bit PASS_NONALPHA = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_wr,
  input  logic [7:0] key_char,
  input  logic       key_last,
  input  logic       key_rewind,
  output logic       key_err,
  output logic       key_ready,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_err
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_KEY_LEN - 1);

  state_t           state;
  logic [PTR_W-1:0] last_idx;  // programmed key length minus one
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] count;
  logic [4:0]       key_mem [MAX_KEY_LEN];

  logic [7:0]       key_off, in_off;
  logic             key_legal, in_letter, accept, overflow;
  logic [4:0]       key_shift, shift_res;
  logic [PTR_W-1:0] wr_idx;

  assign key_off   = key_char - ASCII_A;
  assign in_off    = in_char - ASCII_A;
  assign key_legal = (key_char >= ASCII_A) && (key_char <= ASCII_Z);
  assign in_letter = (in_char >= ASCII_A) && (in_char <= ASCII_Z);
  // Illegal key characters become shift 0 so the stream stays usable.
  assign key_shift = key_legal ? key_off[4:0] : 5'd0;
  assign wr_idx    = (state == LOAD) ? count : '0;
  assign overflow  = (state == LOAD) && !key_last && (count == LAST_SLOT);

  assign key_ready = (state == RUN);
  assign in_ready  = (state == RUN) && !key_wr && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  vigenere_alpha_shift u_shift (
    .p      (in_off[4:0]),
    .k      (key_mem[ptr]),
    .mode   (in_mode),
    .result (shift_res)
  );

  always_ff @(posedge clock) begin
    if (key_wr) key_mem[wr_idx] <= key_shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= NOKEY;
      last_idx <= '0;
      ptr      <= '0;
      count    <= '0;
      key_err  <= 1'b0;
    end else if (key_wr) begin
      ptr <= '0;
      if (state == LOAD) begin
        key_err <= key_err | !key_legal | overflow;
        if (key_last || overflow) begin
          state    <= RUN;
          last_idx <= count;
          count    <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        // A write outside LOAD always begins a fresh key.
        key_err <= !key_legal;
        if (key_last) begin
          state    <= RUN;
          last_idx <= '0;
          count    <= '0;
        end else begin
          state <= LOAD;
          count <= PTR_W'(1);
        end
      end
    end else if (state == RUN) begin
      if (key_rewind)
        ptr <= '0;
      else if (accept && in_letter)
        ptr <= (ptr == last_idx) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_char  <= in_letter ? ({3'b000, shift_res} + ASCII_A) : in_char;
      out_err   <= !in_letter && (PASS_NONALPHA == 1'b0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops them.
module tb_vigenere_stream_cipher;

  logic       clock = 1'b0;
  logic       reset, key_wr, key_last, key_rewind, in_valid, in_mode, out_ready;
  logic [7:0] key_char, in_char;
  logic       key_err, key_ready, in_ready, out_valid, out_err;
  logic [7:0] out_char;
  logic       key_err0, key_ready0, in_ready0, out_valid0, out_err0;
  logic [7:0] out_char0;

  typedef struct {
    logic [7:0] ch;
    logic       err0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  vigenere_stream_cipher #(.MAX_KEY_LEN(10), .PASS_NONALPHA(1'b1)) dut (
    .clock(clock), .reset(reset), .key_wr(key_wr), .key_char(key_char),
    .key_last(key_last), .key_rewind(key_rewind), .key_err(key_err),
    .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_char(out_char), .out_err(out_err)
  );

  vigenere_stream_cipher #(.MAX_KEY_LEN(10), .PASS_NONALPHA(1'b0)) dut0 (
    .clock(clock), .reset(reset), .key_wr(key_wr), .key_char(key_char),
    .key_last(key_last), .key_rewind(key_rewind), .key_err(key_err0),
    .key_ready(key_ready0), .in_valid(in_valid), .in_ready(in_ready0),
    .in_char(in_char), .in_mode(in_mode), .out_valid(out_valid0),
    .out_ready(out_ready), .out_char(out_char0), .out_err(out_err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_key(input string s, input bit final_last);
    for (int i = 0; i < s.len(); i++) begin
      key_wr   = 1'b1;
      key_char = s[i];
      key_last = final_last && (i == s.len() - 1);
      tick();
    end
    key_wr   = 1'b0;
    key_last = 1'b0;
  endtask

  task automatic send(input byte c, input bit m, input byte e, input bit e0, input bit rew);
    bit ok;
    ok         = 1'b0;
    in_valid   = 1'b1;
    in_char    = c;
    in_mode    = m;
    key_rewind = rew;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("send_timeout", 32'(c), 32'hFFFF_FFFF);
    end else begin
      sb.push_back('{ch: e, err0: e0});
      @(posedge clock);
      #1;
    end
    in_valid   = 1'b0;
    key_rewind = 1'b0;
  endtask

  task automatic send_str(input string s, input string e, input bit m);
    for (int i = 0; i < s.len(); i++) send(s[i], m, e[i], 1'b0, 1'b0);
  endtask

  task automatic rewind();
    key_rewind = 1'b1;
    tick();
    key_rewind = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_char), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_char", 32'(out_char), 32'(e.ch));
        check("out_err", 32'(out_err), 32'd0);
        check("strict_valid", 32'(out_valid0), 32'd1);
        check("strict_char", 32'(out_char0), 32'(e.ch));
        check("strict_err", 32'(out_err0), 32'(e.err0));
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1; key_wr = 1'b0; key_char = 8'h00; key_last = 1'b0; key_rewind = 1'b0;
    in_valid = 1'b0; in_char = 8'h00; in_mode = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_char", 32'(out_char), 32'h00);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_key_ready", 32'(key_ready), 32'd0);
    check("rst_key_err", 32'(key_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();

    // Classic LEMON example, full-rate encrypt.
    load_key("LEMON", 1'b1);
    check("lemon_key_err", 32'(key_err), 32'd0);
    check("lemon_key_ready", 32'(key_ready), 32'd1);
    c0 = cyc;
    send_str("ATTACKATDAWN", "LXFOPVEFRNHR", 1'b0);
    check("lemon_rate", 32'(cyc - c0), 32'd12);
    drain("lemon_drain");

    rewind();
    send_str("LXFOPVEFRNHR", "ATTACKATDAWN", 1'b1);
    drain("decrypt_drain");

    // Interleaved modes, then rewind in the same cycle as an accept.
    rewind();
    send("A", 1'b0, "L", 1'b0, 1'b0);
    send("X", 1'b1, "T", 1'b0, 1'b0);
    send("A", 1'b0, "M", 1'b0, 1'b1);
    send("A", 1'b0, "L", 1'b0, 1'b0);
    drain("interleave_drain");

    load_key("B", 1'b1);
    send("A", 1'b0, "B", 1'b0, 1'b0);
    send("-", 1'b0, "-", 1'b1, 1'b0);
    send("Z", 1'b0, "A", 1'b0, 1'b0);
    drain("nonalpha_drain");

    // Backpressure: first output held three cycles.
    out_ready = 1'b0;
    send("H", 1'b0, "I", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_char", 32'(out_char), 32'(8'h49));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    send_str("ELLO", "FMMP", 1'b0);
    drain("bp_drain");

    // Overflow: ten writes without key_last.
    load_key("ABCDEFGHIJ", 1'b0);
    @(negedge clock);
    check("ovf_key_err", 32'(key_err), 32'd1);
    check("ovf_key_ready", 32'(key_ready), 32'd1);
    tick();
    send_str("AAAAAAAAAAA", "ABCDEFGHIJA", 1'b0);
    drain("ovf_drain");
    load_key("C", 1'b0);
    @(negedge clock);
    check("reload_key_err", 32'(key_err), 32'd0);
    check("reload_key_ready", 32'(key_ready), 32'd0);
    tick();
    load_key("D", 1'b1);
    send_str("AA", "CD", 1'b0);
    drain("reload_drain");

    // Illegal key character acts as shift 0.
    load_key("a", 1'b1);
    check("illegal_key_err", 32'(key_err), 32'd1);
    send("Q", 1'b0, "Q", 1'b0, 1'b0);
    drain("illegal_drain");

    // Reset while an output is held.
    out_ready = 1'b0;
    send("Q", 1'b0, "Q", 1'b0, 1'b0);
    @(negedge clock);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    in_valid = 1'b1;
    in_char  = "A";
    @(negedge clock);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_key_ready", 32'(key_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clock);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    load_key("B", 1'b1);
    send("A", 1'b0, "B", 1'b0, 1'b0);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vigenere_stream_cipher.md
Name: vigenere_stream_cipher

Overview:
- Parametrised streaming Vigenère cipher; successor to the fixed 10-character Caesar/Vigenère blocks.
- Key is loaded serially, one character per cycle, with a programmable length of 1..MAX_KEY_LEN.
- Per-character encrypt/decrypt mode; valid/ready handshakes on both input and output streams.
- Key pointer wraps at the programmed key length.
- Sits between the character source and the transmit/compare environment; one unit serves both the encrypt and decrypt paths.

Parameters:
- MAX_KEY_LEN, 10, key storage depth in characters (must be ≥ 2).
- PTR_W, $clog2(MAX_KEY_LEN), key pointer and length-counter width (derived; do not override).
- PASS_NONALPHA, 1, 1 = non-'A'..'Z' input passes through unchanged; 0 = passes through with out_err set.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- key_wr  in  1  key character strobe.
- key_char  in  8  ASCII key character, 'A'..'Z'.
- key_last  in  1  qualifies key_wr; marks the final key character.
- key_rewind  in  1  resets the key pointer to 0.
- key_err  out  1  sticky: illegal key character or overflow since last load start.
- key_ready  out  1  a valid key is loaded (state RUN).
- in_valid  in  1  input character valid.
- in_ready  out  1  input character accepted this cycle when in_valid is also high.
- in_char  in  8  ASCII input character.
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with in_char.
- out_valid  out  1  output character valid.
- out_ready  in  1  downstream accepts the output.
- out_char  out  8  ASCII result.
- out_err  out  1  qualifies out_char: non-letter input while PASS_NONALPHA = 0.

Behaviour:
- Reset values: state NOKEY; key_len 0; ptr 0; load count 0; key_err 0; key_ready 0; out_valid 0; out_char 8'h00; out_err 0. Reset mid-load or mid-stream discards everything, including a held output.
- FSM states: NOKEY, LOAD, RUN.
  - NOKEY: key_wr → LOAD, storing the character at index 0.
  - LOAD: each key_wr stores at count and increments count. key_wr with key_last → RUN, key_len = count+1, ptr = 0.
  - LOAD overflow: the MAX_KEY_LEN-th key_wr without key_last forces RUN with key_len = MAX_KEY_LEN and sets key_err. Further key_wr then starts a new load.
  - RUN: key_wr → LOAD, storing at index 0; count restarts; key_err clears on entry to LOAD.
  - key_last with key_wr in NOKEY or RUN: a 1-character key; go directly to RUN.
- Illegal key character (outside 8'h41..8'h5A): stored as 'A' (shift 0) and key_err set.
- in_ready = (state == RUN) && !key_wr && (!out_valid || out_ready). Combinational path from key_wr and out_ready is permitted.
- Latency: an input accepted at edge N appears registered on out_char/out_valid after edge N. Maximum throughput is 1 character per cycle.
- out_valid stays high and out_char/out_err stay stable until out_ready is high. out_valid clears after a transfer with no new accept.
- A held output survives a transition to LOAD and is still delivered.
- Arithmetic, with p = in_char−'A' and k = key[ptr]−'A', both 5 bits:
  - encrypt: s = p+k (0..50); result = s≥26 ? s−26 : s.
  - decrypt: d = p+26−k (1..51); result = d≥26 ? d−26 : d.
  - Compare-subtract only; no % operator.
  - out_char = result+'A'.
- Pointer advance: only when a letter is accepted; ptr = (ptr == key_len−1) ? 0 : ptr+1.
- Non-letters: out_char = in_char, ptr unchanged, out_err = !PASS_NONALPHA.
- key_rewind:
  - Forces ptr = 0 at the next edge.
  - If a letter is accepted the same cycle, that letter uses the old ptr, then ptr = 0.
  - key_rewind is ignored outside RUN.

Decomposition:
- Package vigenere_pkg holds:
  - ASCII_A = 8'h41, ASCII_Z = 8'h5A, ALPHA_N = 26.
  - state enum {NOKEY, LOAD, RUN}.
  - mode constants MODE_ENC = 0, MODE_DEC = 1.
- Sub-module vigenere_alpha_shift: combinational (p, k, mode) → 5-bit result using the compare-subtract above. Reusable by the Caesar successor.
- Top level holds the FSM, key register file, pointer and output register.

Test Plan:
- Load "LEMON" (5 key_wr, key_last on 'N'); stream "ATTACKATDAWN" encrypt with out_ready = 1 → "LXFOPVEFRNHR", 1 character per cycle, key_err = 0.
- Same key, rewind, stream "LXFOPVEFRNHR" with in_mode = 1 → "ATTACKATDAWN". Interleave the modes, e.g. enc 'A' then dec 'X' → 'L' then 'T'.
- Key "B"; input "A-Z" → "B-A"; '-' does not advance ptr. With PASS_NONALPHA = 0, out_err is high only on '-'.
- Backpressure: hold out_ready = 0 for 3 cycles after the first output → out_char stable, in_ready = 0. The stream completes with no loss or duplication.
- Load MAX_KEY_LEN+1 characters without key_last → key_err = 1, key_len = 10. The 11th key_wr starts a new load; key_err clears.
- Assert reset mid-stream with out_valid = 1 → next cycle out_valid = 0, key_ready = 0. Input not accepted until a new key is loaded.
